// File: rtl/arm_pipe_pkg.sv
// Shared constants and writeback bundle for the register
// write arbiter and its round-robin sub-arbiter.
package arm_pipe_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int ZERO_REG = 31;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the preference flips only
// when both requesters compete in the same cycle.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    // 0 = requester 0 preferred on the next contention
    logic prio_q;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (&valid) begin
            prio_q <= ~prio_q;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register file write port between ALU and load
// writeback; tracks pending writes and forwards staged data.
module reg_write_arbiter
    import arm_pipe_pkg::*;
#(
    parameter int DATA_W      = arm_pipe_pkg::DATA_W,
    parameter int ADDR_W      = arm_pipe_pkg::ADDR_W,
    parameter int NUM_REGS    = arm_pipe_pkg::NUM_REGS,
    parameter int ZERO_REG    = arm_pipe_pkg::ZERO_REG,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                REQ0_VALID,
    output logic                REQ0_READY,
    input  logic [ADDR_W-1:0]   REQ0_ADDR,
    input  logic [DATA_W-1:0]   REQ0_DATA,
    input  logic                REQ1_VALID,
    output logic                REQ1_READY,
    input  logic [ADDR_W-1:0]   REQ1_ADDR,
    input  logic [DATA_W-1:0]   REQ1_DATA,
    input  logic                ISSUE_VALID,
    input  logic [ADDR_W-1:0]   ISSUE_REG,
    input  logic [ADDR_W-1:0]   RD_REG_A,
    input  logic [ADDR_W-1:0]   RD_REG_B,
    input  logic [DATA_W-1:0]   RD_DATA_A,
    input  logic [DATA_W-1:0]   RD_DATA_B,
    output logic [DATA_W-1:0]   FWD_DATA_A,
    output logic [DATA_W-1:0]   FWD_DATA_B,
    output logic                HAZARD_A,
    output logic                HAZARD_B,
    output logic [ADDR_W-1:0]   WRITE_REG,
    output logic [DATA_W-1:0]   WRITE_DATA,
    output logic                REG_WRITE_ENABLE,
    output logic [NUM_REGS-1:0] PENDING
);

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG_EN && (a == ADDR_W'(ZERO_REG));
    endfunction

    wb_req_t       req0;
    wb_req_t       req1;
    wb_req_t       sel;
    logic [1:0]    grant;
    logic          xfer;
    logic          we_q;
    logic [ADDR_W-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_set;
    logic [NUM_REGS-1:0] pending_clr;
    logic          hit_a;
    logic          hit_b;

    assign req0 = '{valid: REQ0_VALID, addr: REQ0_ADDR, data: REQ0_DATA};
    assign req1 = '{valid: REQ1_VALID, addr: REQ1_ADDR, data: REQ1_DATA};

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (RST_N),
        .valid ({req1.valid, req0.valid}),
        .grant (grant)
    );

    assign REQ0_READY = grant[0];
    assign REQ1_READY = grant[1];
    assign xfer       = |grant;
    assign sel        = grant[1] ? req1 : req0;

    always_comb begin
        pending_set = '0;
        pending_clr = '0;
        if (ISSUE_VALID && !is_zero(ISSUE_REG)) begin
            pending_set = NUM_REGS'(1) << ISSUE_REG;
        end
        if (we_q) begin
            pending_clr = NUM_REGS'(1) << wreg_q;
        end
    end

    // Reset drops any staged write before it reaches the register file
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            we_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
        end else begin
            we_q <= xfer && !is_zero(sel.addr);
            if (xfer) begin
                wreg_q  <= sel.addr;
                wdata_q <= sel.data;
            end
            // A newer issue to the same register outranks the commit
            pending_q <= (pending_q & ~pending_clr) | pending_set;
        end
    end

    assign hit_a = we_q && (wreg_q == RD_REG_A);
    assign hit_b = we_q && (wreg_q == RD_REG_B);

    always_comb begin
        FWD_DATA_A = RD_DATA_A;
        FWD_DATA_B = RD_DATA_B;
        if (is_zero(RD_REG_A)) begin
            FWD_DATA_A = '0;
        end else if (hit_a) begin
            FWD_DATA_A = wdata_q;
        end
        if (is_zero(RD_REG_B)) begin
            FWD_DATA_B = '0;
        end else if (hit_b) begin
            FWD_DATA_B = wdata_q;
        end
    end

    assign HAZARD_A = pending_q[RD_REG_A] && !hit_a && !is_zero(RD_REG_A);
    assign HAZARD_B = pending_q[RD_REG_B] && !hit_b && !is_zero(RD_REG_B);

    assign WRITE_REG        = wreg_q;
    assign WRITE_DATA       = wdata_q;
    assign REG_WRITE_ENABLE = we_q;
    assign PENDING          = pending_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench: writes expected on the register file port are
// queued by stimulus and checked by an independent monitor.
module tb_reg_write_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ0_VALID, REQ0_READY;
    logic [4:0]  REQ0_ADDR;
    logic [63:0] REQ0_DATA;
    logic        REQ1_VALID, REQ1_READY;
    logic [4:0]  REQ1_ADDR;
    logic [63:0] REQ1_DATA;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_REG;
    logic [4:0]  RD_REG_A, RD_REG_B;
    logic [63:0] RD_DATA_A, RD_DATA_B;
    logic [63:0] FWD_DATA_A, FWD_DATA_B;
    logic        HAZARD_A, HAZARD_B;
    logic [4:0]  WRITE_REG;
    logic [63:0] WRITE_DATA;
    logic        REG_WRITE_ENABLE;
    logic [31:0] PENDING;

    typedef struct {
        logic [4:0]  r;
        logic [63:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 CLK = ~CLK;

    reg_write_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
        .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
        .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_REG(ISSUE_REG),
        .RD_REG_A(RD_REG_A), .RD_REG_B(RD_REG_B),
        .RD_DATA_A(RD_DATA_A), .RD_DATA_B(RD_DATA_B),
        .FWD_DATA_A(FWD_DATA_A), .FWD_DATA_B(FWD_DATA_B),
        .HAZARD_A(HAZARD_A), .HAZARD_B(HAZARD_B),
        .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA),
        .REG_WRITE_ENABLE(REG_WRITE_ENABLE), .PENDING(PENDING)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [63:0] d);
        wr_t w;
        w.r = r;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Monitor: every enabled write must match the oldest queued one
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (REG_WRITE_ENABLE === 1'b1) begin
                wr_t w;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got reg %0d data %0h expected none",
                             WRITE_REG, WRITE_DATA);
                end else begin
                    w = exp_q.pop_front();
                    if (WRITE_REG !== w.r || WRITE_DATA !== w.d) begin
                        errors++;
                        $display("FAIL write: got reg %0d data %0h expected reg %0d data %0h",
                                 WRITE_REG, WRITE_DATA, w.r, w.d);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d0 [4];
        logic [63:0] d1 [4];
        logic [1:0]  g  [4];
        d0 = '{64'h200, 64'h201, 64'h201, 64'h202};
        d1 = '{64'h300, 64'h300, 64'h301, 64'h301};
        g  = '{2'b01, 2'b10, 2'b01, 2'b10};

        RST_N = 1'b0;
        REQ0_VALID = 0; REQ0_ADDR = 0; REQ0_DATA = 0;
        REQ1_VALID = 0; REQ1_ADDR = 0; REQ1_DATA = 0;
        ISSUE_VALID = 0; ISSUE_REG = 0;
        RD_REG_A = 0; RD_REG_B = 0; RD_DATA_A = 0; RD_DATA_B = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("rst_we", REG_WRITE_ENABLE, 0);
        chk("rst_pending", PENDING, 0);
        chk("rst_ready", {REQ1_READY, REQ0_READY}, 0);
        chk("rst_wreg", WRITE_REG, 0);
        chk("rst_wdata", WRITE_DATA, 0);

        // Single REQ0 write of X1 with forwarding
        @(negedge CLK);
        REQ0_VALID = 1; REQ0_ADDR = 1; REQ0_DATA = 64'hA;
        #1;
        chk("single_ready", {REQ1_READY, REQ0_READY}, 2'b01);
        push(1, 64'hA);
        @(negedge CLK);
        REQ0_VALID = 0;
        RD_REG_A = 1; RD_DATA_A = 64'h55;
        #1;
        chk("fwd_a_hit", FWD_DATA_A, 64'hA);
        chk("haz_a_hit", HAZARD_A, 0);
        @(negedge CLK);
        #1;
        chk("fwd_a_raw", FWD_DATA_A, 64'h55);

        // Contention: grants alternate, loser holds its request
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            REQ0_VALID = 1; REQ0_ADDR = 2; REQ0_DATA = d0[i];
            REQ1_VALID = 1; REQ1_ADDR = 3; REQ1_DATA = d1[i];
            #1;
            chk($sformatf("rr_grant%0d", i), {REQ1_READY, REQ0_READY}, g[i]);
            if (g[i][0]) push(2, d0[i]);
            else push(3, d1[i]);
        end
        @(negedge CLK);
        REQ0_VALID = 0; REQ1_VALID = 0;

        // Scoreboard set, hazard, commit clear
        @(negedge CLK);
        ISSUE_VALID = 1; ISSUE_REG = 4;
        RD_REG_A = 4; RD_DATA_A = 64'h99;
        #1;
        chk("sb_pre", PENDING, 0);
        @(negedge CLK);
        ISSUE_VALID = 0;
        #1;
        chk("sb_set", PENDING, 32'h10);
        chk("sb_haz", HAZARD_A, 1);
        REQ0_VALID = 1; REQ0_ADDR = 4; REQ0_DATA = 64'h44;
        push(4, 64'h44);
        @(negedge CLK);
        REQ0_VALID = 0;
        #1;
        chk("sb_fwd", FWD_DATA_A, 64'h44);
        chk("sb_haz_fwd", HAZARD_A, 0);
        chk("sb_still", PENDING, 32'h10);
        @(negedge CLK);
        #1;
        chk("sb_clr", PENDING, 0);
        chk("sb_haz_clr", HAZARD_A, 0);
        chk("sb_raw", FWD_DATA_A, 64'h99);

        // Issue and commit of X4 at the same edge keeps it pending
        REQ0_VALID = 1; REQ0_ADDR = 4; REQ0_DATA = 64'h45;
        push(4, 64'h45);
        @(negedge CLK);
        REQ0_VALID = 0;
        ISSUE_VALID = 1; ISSUE_REG = 4;
        @(negedge CLK);
        ISSUE_VALID = 0;
        #1;
        chk("sb_set_wins", PENDING, 32'h10);
        chk("sb_set_haz", HAZARD_A, 1);
        REQ0_VALID = 1; REQ0_ADDR = 4; REQ0_DATA = 64'h46;
        push(4, 64'h46);
        @(negedge CLK);
        REQ0_VALID = 0;
        @(negedge CLK);
        #1;
        chk("sb_final_clr", PENDING, 0);

        // Zero register: granted, never written, never pending
        REQ1_VALID = 1; REQ1_ADDR = 31; REQ1_DATA = 64'hFFFF;
        #1;
        chk("xzr_ready", {REQ1_READY, REQ0_READY}, 2'b10);
        @(negedge CLK);
        REQ1_VALID = 0;
        ISSUE_VALID = 1; ISSUE_REG = 31;
        RD_REG_B = 31; RD_DATA_B = 64'h1234;
        #1;
        chk("xzr_we", REG_WRITE_ENABLE, 0);
        chk("xzr_fwd", FWD_DATA_B, 0);
        chk("xzr_haz", HAZARD_B, 0);
        @(negedge CLK);
        ISSUE_VALID = 0;
        #1;
        chk("xzr_pending", PENDING, 0);

        // Reset right after a contended grant drops the staged write
        @(negedge CLK);
        ISSUE_VALID = 1; ISSUE_REG = 5;
        REQ0_VALID = 1; REQ0_ADDR = 6; REQ0_DATA = 64'h66;
        REQ1_VALID = 1; REQ1_ADDR = 7; REQ1_DATA = 64'h77;
        #1;
        chk("mid_grant", {REQ1_READY, REQ0_READY}, 2'b01);
        @(negedge CLK);
        ISSUE_VALID = 0; REQ0_VALID = 0; REQ1_VALID = 0;
        RST_N = 1'b0;
        #1;
        chk("mid_we", REG_WRITE_ENABLE, 0);
        chk("mid_pending", PENDING, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        REQ0_VALID = 1; REQ0_ADDR = 6; REQ0_DATA = 64'h67;
        REQ1_VALID = 1; REQ1_ADDR = 7; REQ1_DATA = 64'h77;
        #1;
        chk("post_rst_ptr", {REQ1_READY, REQ0_READY}, 2'b01);
        push(6, 64'h67);
        @(negedge CLK);
        REQ0_VALID = 0; REQ1_VALID = 0;
        repeat (3) @(negedge CLK);
        #3;
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the register file's single synchronous write port between two writeback requesters: REQ0 (ALU/execute writeback) and REQ1 (load writeback from memory stage).
- Keeps a 32-bit pending-write scoreboard, set at issue and cleared when the write is committed.
- Provides hazard flags and same-cycle write-to-read forwarding for the register file's two asynchronous read ports.
- Sits between the pipeline writeback stage and REG_MEM.

Parameters:
- DATA_W, 64, register data width
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of architectural registers (2**ADDR_W)
- ZERO_REG, 31, index of the hardwired-zero register (XZR)
- ZERO_REG_EN, 1, 1 = writes to ZERO_REG are discarded and it is never marked pending

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ0_VALID  in  1  ALU writeback request
- REQ0_READY  out  1  ALU request granted this cycle
- REQ0_ADDR  in  ADDR_W  destination register for REQ0
- REQ0_DATA  in  DATA_W  write data for REQ0
- REQ1_VALID / REQ1_READY / REQ1_ADDR / REQ1_DATA  same as REQ0, for load writeback
- ISSUE_VALID  in  1  an instruction with a register destination issues this cycle
- ISSUE_REG  in  ADDR_W  destination register of the issuing instruction
- RD_REG_A, RD_REG_B  in  ADDR_W  copies of the register file read addresses
- RD_DATA_A, RD_DATA_B  in  DATA_W  raw register file read data
- FWD_DATA_A, FWD_DATA_B  out  DATA_W  read data after forwarding
- HAZARD_A, HAZARD_B  out  1  source register has an uncommitted pending write
- WRITE_REG  out  ADDR_W  to register file
- WRITE_DATA  out  DATA_W  to register file
- REG_WRITE_ENABLE  out  1  to register file
- PENDING  out  NUM_REGS  scoreboard, bit i = register i has a pending write

Behaviour:
- Reset (async, RST_N low): REG_WRITE_ENABLE=0, WRITE_REG=0, WRITE_DATA=0, PENDING=0, round-robin pointer=REQ0 preferred. REQ*_READY is combinational and is 0 when both VALIDs are 0.
- Reset mid-operation: any staged write is dropped and is not committed. The scoreboard is cleared.
- Arbitration:
  - Only REQ0 valid: grant REQ0. Only REQ1 valid: grant REQ1.
  - Both valid: grant the requester not granted last time both competed. The pointer updates only on contention.
  - READYx = grantx. It may depend combinationally on VALIDs; the requester must not wait on READY before asserting VALID.
  - At most one READY is high per cycle.
- Handshake: transfer at a rising edge where VALIDx && READYx. The requester holds ADDR and DATA stable while VALID is high and READY is low.
- Output stage: one register.
  - A transfer at edge N drives WRITE_REG/WRITE_DATA, with REG_WRITE_ENABLE=1, during cycle N..N+1. REG_MEM commits at edge N+1.
  - Latency from accept to architectural commit: 2 edges. The stage accepts every cycle and never stalls.
- Zero register: with ZERO_REG_EN=1, a request to ZERO_REG is still granted and handshaken, but REG_WRITE_ENABLE stays 0 for it.
- Scoreboard:
  - ISSUE_VALID sets PENDING[ISSUE_REG], except ZERO_REG.
  - A committing write (REG_WRITE_ENABLE=1 at the edge) clears PENDING[WRITE_REG].
  - Set and clear of the same register at the same edge: set wins, because a newer writer is in flight.
  - Setting an already-pending bit leaves it 1. A single bit is kept per register; the issue logic must not issue two outstanding writers to the same register.
- Forwarding: if REG_WRITE_ENABLE && WRITE_REG==RD_REG_x, then FWD_DATA_x=WRITE_DATA. Otherwise FWD_DATA_x=RD_DATA_x. RD_REG_x==ZERO_REG (with ZERO_REG_EN) gives 0.
- Hazard: HAZARD_x = PENDING[RD_REG_x] && !(forward hit on x). It is 0 for ZERO_REG.
- Both hazard and forwarding paths are purely combinational, with no added latency.

Decomposition:
- Shared package `arm_pipe_pkg`: ADDR_W, DATA_W, NUM_REGS, ZERO_REG constants, and a wb_req_t struct {valid, addr, data}.
- One natural sub-module: `rr_arb2`, a 2-way round-robin arbiter (valids in, one-hot grant out, pointer register). Scoreboard and forwarding stay in the top level.

Test Plan:
- Reset: hold RST_N=0, then release → REG_WRITE_ENABLE=0, PENDING=0, READYs=0 with VALIDs low.
- Single request: REQ0 write X1=0xA at edge N → WE=1, WRITE_REG=1, WRITE_DATA=0xA during N..N+1. A read of X1 in that cycle gives FWD_DATA_A=0xA.
- Contention: both valid for 4 cycles (REQ0→X2, REQ1→X3) → grants alternate REQ0, REQ1, REQ0, REQ1, and each requester holds until granted.
- Scoreboard: ISSUE X4 → PENDING[4]=1 and HAZARD_A=1 for RD_REG_A=4. The commit of X4 clears it. ISSUE X4 at the same edge as the commit of X4 → PENDING[4] stays 1.
- Zero register: REQ1 write X31=0xFFFF → READY1=1, REG_WRITE_ENABLE=0. ISSUE X31 → PENDING unchanged. A read of X31 gives 0.
- Reset mid-op: assert RST_N low the cycle after a grant → no write is committed, and PENDING=0.
